div16_seq: RTL
==============

# div16_seq

Sequential 16-bit unsigned restoring divider for the 16-bit arithmetic datapath. It performs the inverse of the multiply path: it consumes a dividend/divisor pair through a start/done handshake and produces a quotient and remainder, one quotient bit per cycle. Each iteration uses a subtract step of the form `a + ~b + 1`, where carry-out high means no borrow. This is the same arithmetic form used elsewhere in the ALU. The divider sits beside the 16-bit ALU as a multi-cycle functional unit, driven by the controller.

## Interface
Parameters:
- none (width fixed at 16)

Ports (one clock; reset is synchronous and active-low):
- clk — input, 1 — rising-edge clock.
- rst_n — input, 1 — synchronous active-low reset.
- start — input, 1 — request a division. Sampled only in IDLE.
- dividend — input, 16 — numerator. Captured on the accepted start.
- divisor — input, 16 — denominator. Captured on the accepted start.
- busy — output, 1 — high from the cycle after accept until done drops.
- done — output, 1 — one-cycle pulse; results are valid during and after it.
- quotient — output, 16 — unsigned quotient.
- remainder — output, 16 — unsigned remainder.
- div_by_zero — output, 1 — high when the last accepted divisor was 0.

## Operation
- Reset: when rst_n=0 at a rising edge:
  - State goes to IDLE.
  - busy, done, quotient, remainder, div_by_zero, and all internal registers go to 0.
  - Reset mid-operation abandons the division; no done is produced.
- States: IDLE → RUN → DONE → IDLE.
- IDLE, start=1, divisor≠0:
  - Load the dividend into the quotient shift register and clear the 17-bit partial remainder P.
  - Set the iteration counter to 0, clear div_by_zero, go to RUN.
- IDLE, start=1, divisor=0:
  - Set quotient=16'hFFFF, remainder=dividend, div_by_zero=1.
  - Go to DONE with no RUN cycles.
- RUN iteration (one per cycle, 16 total):
  - Form T = {P[15:0], Q[15]} as a 17-bit value.
  - Compute D = T + ~{1'b0,divisor} + 1 at 17 bits, keeping the carry-out.
  - Carry-out 1 (no borrow): P ← D and Q ← {Q[14:0],1}.
  - Carry-out 0: P ← T and Q ← {Q[14:0],0}.
  - Increment the counter. After the iteration with counter=15, go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - quotient=Q and remainder=P[15:0]. P[16] is always 0 here.
  - Go to IDLE next cycle.
- Outputs hold their values until the next accepted start. Starting a new division clears div_by_zero at accept.
- start while in RUN or DONE is ignored; it is neither queued nor able to corrupt the current operation.
- The 17-bit partial remainder is mandatory. A 16-bit version fails when P[15]=1 before the shift (e.g. 16'hFFFF / 16'h8000).

## Timing
- The accept edge is the rising edge with state=IDLE and start=1.
- Normal division:
  - RUN occupies the 16 cycles after accept.
  - done is high in the 17th cycle after the accept edge, i.e. 17 clocks of latency.
  - busy is high in cycles 1–17 after accept, including the DONE cycle, and low again in cycle 18.
- Divide-by-zero:
  - done is high in cycle 1 after accept. busy is high in that cycle only.
- start held high continuously: a new operation is accepted at the first edge back in IDLE, i.e. cycle 18 after the previous accept (normal path) or cycle 2 (divide-by-zero path). Throughput is one division per 18 cycles.
- Inputs dividend/divisor are only sampled at accept; changes afterwards have no effect.
- No combinational path from inputs to outputs.

## Test plan
- Basic: 100 / 7.
  - done at cycle 17 with quotient=14, remainder=2, div_by_zero=0.
  - busy high in cycles 1–17.
- Extremes:
  - 16'hFFFF / 1 gives quotient=16'hFFFF, remainder=0.
  - 16'hFFFF / 16'h8000 gives quotient=1, remainder=16'h7FFF (17-bit remainder check).
  - 3 / 16'hFFFF gives quotient=0, remainder=3.
- Divide by zero: 5 / 0.
  - done at cycle 1, quotient=16'hFFFF, remainder=5, div_by_zero=1.
  - A following 9 / 3 gives quotient=3, remainder=0, div_by_zero=0.
- Start while busy: accept 1000 / 10, then pulse start with 50 / 5 at cycle 8.
  - Result is quotient=100, remainder=0 at cycle 17.
  - There is exactly one done pulse.
- Reset mid-operation: rst_n=0 at cycle 9 of a division.
  - Next cycle all outputs are 0 and state is IDLE.
  - No done appears.
  - A new 20 / 6 gives quotient=3, remainder=2 with 17-cycle latency.
- Random: 10k random pairs with divisor≠0, checked against a reference model for quotient, remainder, and exact done timing.

Source files
------------

// File: rtl/div16_seq_if.sv
// Handshake and data bundle between the controller and the 16-bit sequential divider.
interface div16_seq_if;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  // Controller side: issues requests, observes results.
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side: accepts requests, produces results.
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div16_seq.sv
// 16-bit unsigned restoring divider, one quotient bit per clock.
// Request accepted in IDLE; 16 RUN iterations; one-cycle done pulse in DONE.
// Divide-by-zero short-circuits straight to DONE with a saturated quotient.
module div16_seq (
  input  logic        clk,
  input  logic        rst_n,
  div16_seq_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [16:0] r_p;        // partial remainder
  logic [15:0] r_q;        // dividend shifting out, quotient shifting in
  logic [15:0] r_divisor;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_quot;
  logic [15:0] r_rem;
  logic        r_dbz;

  logic [16:0] w_t;
  logic [17:0] w_sum;
  logic        w_no_borrow;
  logic [16:0] w_p_next;
  logic [15:0] w_q_next;
  // P[16] is always 0 between iterations (P < divisor), so only the
  // shifted-in 17-bit trial value T needs the extra bit.
  logic        w_unused_bits;

  // One restoring step: trial subtract T - divisor as T + ~divisor + 1.
  always_comb begin
    w_t         = {r_p[15:0], r_q[15]};
    w_sum       = {1'b0, w_t} + {1'b0, ~{1'b0, r_divisor}} + 18'd1;
    w_no_borrow = w_sum[17];
    if (w_no_borrow) begin
      w_p_next = w_sum[16:0];
      w_q_next = {r_q[14:0], 1'b1};
    end else begin
      w_p_next = w_t;
      w_q_next = {r_q[14:0], 1'b0};
    end
  end

  assign w_unused_bits = &{r_p[16], w_p_next[16], 1'b0};

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_p       <= '0;
      r_q       <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_dbz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy <= 1'b1;
            if (bus.divisor == 16'd0) begin
              r_quot  <= 16'hFFFF;
              r_rem   <= bus.dividend;
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_q       <= bus.dividend;
              r_p       <= '0;
              r_cnt     <= '0;
              r_divisor <= bus.divisor;
              r_dbz     <= 1'b0;
              r_state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_p   <= w_p_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_quot  <= w_q_next;
            r_rem   <= w_p_next[15:0];
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;

endmodule
